// File: rtl/tagv_ctrl_if.sv
// Bundle of the lookup/refill/invalidate handshakes and the external tag/valid array port.
// The controller takes the slave side; whoever drives requests and owns the array takes the master side.
interface tagv_ctrl_if #(
    parameter int TAG_WIDTH   = 20,
    parameter int INDEX_WIDTH = 6,
    parameter int WAYS        = 2
) ();
    logic                   lookup_valid;
    logic [INDEX_WIDTH-1:0] lookup_index;
    logic [TAG_WIDTH-1:0]   lookup_tag;
    logic                   lookup_ready;
    logic                   hit_valid;
    logic                   hit;
    logic                   hit_way;

    logic                   refill_valid;
    logic [INDEX_WIDTH-1:0] refill_index;
    logic [TAG_WIDTH-1:0]   refill_tag;
    logic                   refill_way;
    logic                   refill_ready;

    logic                   ibar_req;
    logic                   ibar_busy;
    logic                   ibar_done;

    logic [INDEX_WIDTH-1:0] tagv_raddr;
    logic [INDEX_WIDTH-1:0] tagv_waddr;
    logic [TAG_WIDTH:0]     tagv_din;
    logic [WAYS-1:0]        tagv_we;
    logic [TAG_WIDTH:0]     tagv_dout0;
    logic [TAG_WIDTH:0]     tagv_dout1;

    modport slave (
        input  lookup_valid, lookup_index, lookup_tag,
        output lookup_ready, hit_valid, hit, hit_way,
        input  refill_valid, refill_index, refill_tag, refill_way,
        output refill_ready,
        input  ibar_req,
        output ibar_busy, ibar_done,
        output tagv_raddr, tagv_waddr, tagv_din, tagv_we,
        input  tagv_dout0, tagv_dout1
    );

    modport master (
        output lookup_valid, lookup_index, lookup_tag,
        input  lookup_ready, hit_valid, hit, hit_way,
        output refill_valid, refill_index, refill_tag, refill_way,
        input  refill_ready,
        output ibar_req,
        input  ibar_busy, ibar_done,
        input  tagv_raddr, tagv_waddr, tagv_din, tagv_we,
        output tagv_dout0, tagv_dout1
    );
endinterface

// File: rtl/tagv_ctrl.sv
// Two-way tag/valid array controller: pipelined lookups, refill writes and a
// whole-array invalidation walk that clears one set per cycle.
module tagv_ctrl #(
    parameter int TAG_WIDTH   = 20,
    parameter int INDEX_WIDTH = 6,
    parameter int WAYS        = 2
) (
    input logic        clk,
    input logic        rst,
    tagv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INVAL = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [INDEX_WIDTH-1:0] LastSet = '1;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] setCnt_q, setCnt_d;
    logic                   hitValid_q;
    logic [TAG_WIDTH-1:0]   lookupTag_q;

    logic lookupFire;
    logic way0Match;
    logic way1Match;

    assign lookupFire = bus.lookup_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            setCnt_q   <= '0;
            hitValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            setCnt_q   <= setCnt_d;
            hitValid_q <= lookupFire;
        end
    end

    always_ff @(posedge clk) begin
        if (lookupFire) begin
            lookupTag_q <= bus.lookup_tag;
        end
    end

    always_comb begin
        state_d          = state_q;
        setCnt_d         = setCnt_q;
        bus.lookup_ready = 1'b0;
        bus.refill_ready = 1'b0;
        bus.ibar_busy    = 1'b0;
        bus.ibar_done    = 1'b0;
        bus.tagv_waddr   = bus.refill_index;
        bus.tagv_din     = {1'b1, bus.refill_tag};
        bus.tagv_we      = '0;
        case (state_q)
            IDLE: begin
                bus.lookup_ready = 1'b1;
                bus.refill_ready = 1'b1;
                if (bus.refill_valid) begin
                    bus.tagv_we[bus.refill_way] = 1'b1;
                end
                // A refill in the same cycle still lands; the walk starts next cycle.
                if (bus.ibar_req) begin
                    state_d  = INVAL;
                    setCnt_d = '0;
                end
            end
            INVAL: begin
                bus.ibar_busy  = 1'b1;
                bus.tagv_waddr = setCnt_q;
                bus.tagv_din   = '0;
                bus.tagv_we    = '1;
                setCnt_d       = setCnt_q + 1'b1;
                if (setCnt_q == LastSet) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.ibar_done = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Way 0 wins when both ways hold the tag.
    assign bus.tagv_raddr = bus.lookup_index;
    assign way0Match      = bus.tagv_dout0[TAG_WIDTH] && (bus.tagv_dout0[TAG_WIDTH-1:0] == lookupTag_q);
    assign way1Match      = bus.tagv_dout1[TAG_WIDTH] && (bus.tagv_dout1[TAG_WIDTH-1:0] == lookupTag_q);
    assign bus.hit_valid  = hitValid_q;
    assign bus.hit        = hitValid_q && (way0Match || way1Match);
    assign bus.hit_way    = hitValid_q && !way0Match && way1Match;

endmodule

// File: tb/tb_tagv_ctrl.sv
// Scoreboard bench for tagv_ctrl: directed lookups/refills/walks against a
// write-first two-way array model; lookup results are checked by a separate monitor.
module tb_tagv_ctrl;

    localparam int TW = 20;
    localparam int IW = 6;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    logic sawDone;

    typedef struct {
        logic hit;
        logic way;
        int   cyc;
    } exp_t;

    exp_t sbQ[$];

    logic [TW:0] mem0[2**IW];
    logic [TW:0] mem1[2**IW];

    tagv_ctrl_if #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .WAYS(2)) bus ();

    tagv_ctrl #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .WAYS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first synchronous array: a same-cycle write to the read index is forwarded.
    always @(posedge clk) begin
        if (bus.tagv_we[0]) mem0[bus.tagv_waddr] <= bus.tagv_din;
        if (bus.tagv_we[1]) mem1[bus.tagv_waddr] <= bus.tagv_din;
        bus.tagv_dout0 <= (bus.tagv_we[0] && bus.tagv_waddr == bus.tagv_raddr) ? bus.tagv_din : mem0[bus.tagv_raddr];
        bus.tagv_dout1 <= (bus.tagv_we[1] && bus.tagv_waddr == bus.tagv_raddr) ? bus.tagv_din : mem1[bus.tagv_raddr];
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.hit_valid === 1'b1) begin
            total = total + 1;
            if (sbQ.size() == 0) begin
                bad = bad + 1;
                $display("[TB] FAIL unexpectedResult hit=%0b way=%0b required no result (cycle %0d)", bus.hit, bus.hit_way, cyc);
            end else begin
                e = sbQ.pop_front();
                if ({bus.hit, bus.hit_way} !== {e.hit, e.way}) begin
                    bad = bad + 1;
                    $display("[TB] FAIL lookupResult hit=%0b way=%0b required hit=%0b way=%0b (cycle %0d)", bus.hit, bus.hit_way, e.hit, e.way, cyc);
                end
            end
        end else if (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
            total = total + 1;
            bad   = bad + 1;
            e     = sbQ.pop_front();
            $display("[TB] FAIL missingResult hit_valid=%b required 1 (cycle %0d)", bus.hit_valid, cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [IW-1:0] li, input logic [TW-1:0] lt,
                                 input logic rv, input logic [IW-1:0] ri, input logic [TW-1:0] rt,
                                 input logic rw, input logic ib);
        @(posedge clk);
        #1;
        rst              = r;
        bus.lookup_valid = lv;
        bus.lookup_index = li;
        bus.lookup_tag   = lt;
        bus.refill_valid = rv;
        bus.refill_index = ri;
        bus.refill_tag   = rt;
        bus.refill_way   = rw;
        bus.ibar_req     = ib;
    endtask

    task automatic pushExp(input logic h, input logic w);
        exp_t e;
        e.hit = h;
        e.way = w;
        e.cyc = cyc;
        sbQ.push_back(e);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic refill(input logic [IW-1:0] idx, input logic way, input logic [TW-1:0] tag);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, idx, tag, way, 1'b0);
    endtask

    task automatic lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic h, input logic w);
        applyStimulus(1'b0, 1'b1, idx, tag, 1'b0, '0, '0, 1'b0, 1'b0);
        pushExp(h, w);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2**IW; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        bus.tagv_dout0 = '0;
        bus.tagv_dout1 = '0;
        rst = 1'b1;
        bus.lookup_valid = 1'b0; bus.lookup_index = '0; bus.lookup_tag = '0;
        bus.refill_valid = 1'b0; bus.refill_index = '0; bus.refill_tag = '0;
        bus.refill_way = 1'b0; bus.ibar_req = 1'b0;

        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("resetHitValid", 32'(bus.hit_valid), 32'd0);
        checkOutput("resetHit", 32'(bus.hit), 32'd0);
        checkOutput("resetHitWay", 32'(bus.hit_way), 32'd0);
        checkOutput("resetBusy", 32'(bus.ibar_busy), 32'd0);
        checkOutput("resetDone", 32'(bus.ibar_done), 32'd0);
        checkOutput("resetWe", 32'(bus.tagv_we), 32'd0);
        checkOutput("resetReady", 32'({bus.lookup_ready, bus.refill_ready}), 32'd3);

        refill(6'd5, 1'b1, 20'hABCDE);
        @(negedge clk);
        checkOutput("refillWe", 32'(bus.tagv_we), 32'd2);
        checkOutput("refillWaddr", 32'(bus.tagv_waddr), 32'd5);
        checkOutput("refillDin", 32'(bus.tagv_din), 32'h1ABCDE);
        lookup(6'd5, 20'hABCDE, 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b1, 6'd9, 20'h12345, 1'b1, 6'd9, 20'h12345, 1'b0, 1'b0);
        pushExp(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sameCycleWe", 32'(bus.tagv_we), 32'd1);

        refill(6'd3, 1'b0, 20'h00007);
        refill(6'd3, 1'b1, 20'h00007);
        lookup(6'd3, 20'h00007, 1'b1, 1'b0);
        refill(6'd5, 1'b0, 20'h22222);
        lookup(6'd5, 20'hABCDE, 1'b1, 1'b1);
        lookup(6'd5, 20'h22222, 1'b1, 1'b0);
        lookup(6'd5, 20'h11111, 1'b0, 1'b0);
        lookup(6'd3, 20'h00008, 1'b0, 1'b0);
        lookup(6'd9, 20'h12345, 1'b1, 1'b0);
        refill(6'd40, 1'b0, 20'h55555);
        lookup(6'd40, 20'h55555, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("idleWe", 32'(bus.tagv_we), 32'd0);

        // Lookup presented together with reset must not produce a result.
        applyStimulus(1'b1, 1'b1, 6'd40, 20'h55555, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("lookupAtResetDropped", 32'(bus.hit_valid), 32'd0);

        // Full walk; ibar_req held through the walk must not restart it.
        applyStimulus(1'b0, 1'b1, 6'd9, 20'h12345, 1'b0, '0, '0, 1'b0, 1'b1);
        pushExp(1'b1, 1'b0);
        for (int k = 1; k <= 66; k++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, (k <= 65) ? 1'b1 : 1'b0);
            @(negedge clk);
            if (k <= 64) begin
                checkOutput("walkBusy", 32'(bus.ibar_busy), 32'd1);
                checkOutput("walkWaddr", 32'(bus.tagv_waddr), 32'(k - 1));
                checkOutput("walkWe", 32'(bus.tagv_we), 32'd3);
                checkOutput("walkDin", 32'(bus.tagv_din), 32'd0);
                checkOutput("walkDone", 32'(bus.ibar_done), 32'd0);
                checkOutput("walkReady", 32'(bus.lookup_ready), 32'd0);
            end else if (k == 65) begin
                checkOutput("doneDone", 32'(bus.ibar_done), 32'd1);
                checkOutput("doneBusy", 32'(bus.ibar_busy), 32'd0);
                checkOutput("doneReady", 32'(bus.lookup_ready), 32'd0);
            end else begin
                checkOutput("afterDone", 32'(bus.ibar_done), 32'd0);
                checkOutput("afterBusy", 32'(bus.ibar_busy), 32'd0);
                checkOutput("afterReady", 32'(bus.lookup_ready), 32'd1);
            end
        end
        idle();
        @(negedge clk);
        checkOutput("noRequeue", 32'(bus.ibar_busy), 32'd0);
        lookup(6'd5, 20'hABCDE, 1'b0, 1'b0);
        lookup(6'd9, 20'h12345, 1'b0, 1'b0);
        lookup(6'd3, 20'h00007, 1'b0, 1'b0);
        lookup(6'd40, 20'h55555, 1'b0, 1'b0);

        // Requests held during a walk stall until the controller is idle again.
        idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 66; k++) begin
            applyStimulus(1'b0, 1'b1, 6'd12, 20'h00003, 1'b1, 6'd12, 20'h00003, 1'b1, 1'b0);
            @(negedge clk);
            if (k < 66) begin
                checkOutput("stallReady", 32'({bus.lookup_ready, bus.refill_ready}), 32'd0);
            end else begin
                checkOutput("resumeReady", 32'({bus.lookup_ready, bus.refill_ready}), 32'd3);
                checkOutput("resumeWe", 32'(bus.tagv_we), 32'd2);
                pushExp(1'b1, 1'b1);
            end
        end
        idle();
        lookup(6'd12, 20'h00003, 1'b1, 1'b1);

        // Walk aborted by reset partway through.
        refill(6'd40, 1'b0, 20'h55555);
        refill(6'd18, 1'b0, 20'h00018);
        refill(6'd5, 1'b1, 20'hABCDE);
        refill(6'd50, 1'b1, 20'h00050);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 19; k++) idle();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("abortBusy", 32'(bus.ibar_busy), 32'd0);
        checkOutput("abortDone", 32'(bus.ibar_done), 32'd0);
        checkOutput("abortReady", 32'(bus.lookup_ready), 32'd1);
        sawDone = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            idle();
            @(negedge clk);
            if (bus.ibar_done !== 1'b0) sawDone = 1'b1;
        end
        checkOutput("noDoneAfterAbort", 32'(sawDone), 32'd0);
        lookup(6'd18, 20'h00018, 1'b0, 1'b0);
        lookup(6'd5, 20'hABCDE, 1'b0, 1'b0);
        lookup(6'd40, 20'h55555, 1'b1, 1'b0);
        lookup(6'd50, 20'h00050, 1'b1, 1'b1);

        idle();
        idle();
        idle();
        @(negedge clk);
        checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
